pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the fetch/decode/execute/memory core.
- Detects RAW hazards on the integer and vector register files and stalls decode; the core has no forwarding.
- Flushes younger stages on a taken jump resolved in the memory stage.
- Drains and halts the pipeline on the end flag, and keeps saturating performance counters.

Parameters:
REGI_BITS, 4, integer register index width
VECT_BITS, 2, vector register index width
DRAIN_CYCLES, 2, cycles held in DRAIN after end before HALTED (>=1)
CNT_BITS, 16, width of stall/jump counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
id_valid_i  in  1  decode holds a real instruction (not NOP)
id_src1_int_i  in  REGI_BITS  decode integer source 1
id_src2_int_i  in  REGI_BITS  decode integer source 2
id_use1_int_i  in  1  source 1 integer read enable
id_use2_int_i  in  1  source 2 integer read enable
id_src1_vec_i  in  VECT_BITS  decode vector source 1
id_src2_vec_i  in  VECT_BITS  decode vector source 2
id_use1_vec_i  in  1  source 1 vector read enable
id_use2_vec_i  in  1  source 2 vector read enable
ex_wr_int_i  in  1  execute-stage instr writes integer reg
ex_dest_int_i  in  REGI_BITS  its integer destination
ex_wr_vec_i  in  1  execute-stage instr writes vector reg
ex_dest_vec_i  in  VECT_BITS  its vector destination
mem_wr_int_i  in  1  memory-stage instr writes integer reg
mem_dest_int_i  in  REGI_BITS  its integer destination
mem_wr_vec_i  in  1  memory-stage instr writes vector reg
mem_dest_vec_i  in  VECT_BITS  its vector destination
jump_taken_i  in  1  taken jump in memory stage (enableJump_f)
end_i  in  1  end instruction in memory stage (flagEnd_f)
pc_we_o  out  1  PC register update enable
ifid_we_o  out  1  IF/ID pipe register load enable
ifid_flush_o  out  1  clear IF/ID to NOP
idex_flush_o  out  1  clear ID/EX to NOP (bubble)
exmem_flush_o  out  1  clear EX/MEM to NOP
pc_sel_jump_o  out  1  PC mux selects jump address
halted_o  out  1  pipeline halted
state_o  out  2  0=INIT 1=RUN 2=DRAIN 3=HALTED
stall_cnt_o  out  CNT_BITS  total stall cycles, saturating
jump_cnt_o  out  CNT_BITS  total taken jumps, saturating

Behaviour:
- Registered: state, drain counter, stall_cnt, jump_cnt. All control outputs are combinational from the registered state and current inputs.
- rst_i low, asynchronous: state=INIT, counters=0, drain counter=DRAIN_CYCLES.
- INIT outputs: pc_we=0, ifid_we=0, all three flushes=1, pc_sel_jump=0, halted=0. INIT lasts exactly one cycle after rst_i rises, then goes to RUN.
- hazard = id_valid_i AND any enabled source index equals a writing EX or MEM destination of the same file (int vs int, vec vs vec). All indices compare, including 0. Int and vector never alias.
- RUN, priority end > jump > hazard > normal:
  - end_i: pc_we=0, ifid_we=0, all flushes=1, pc_sel_jump=0; next state DRAIN. A simultaneous jump_taken_i is ignored and does not count.
  - jump_taken_i: pc_we=1, pc_sel_jump=1, ifid_we=1, all flushes=1; jump_cnt+1. Any hazard that cycle is ignored and does not count as a stall.
  - hazard: pc_we=0, ifid_we=0, idex_flush=1, other flushes=0; stall_cnt+1.
  - normal: pc_we=1, ifid_we=1, flushes=0, pc_sel_jump=0.
- DRAIN: same outputs as the end_i cycle. Drain counter decrements each cycle; on the cycle it reads 1, next state is HALTED. jump_taken_i and end_i are ignored.
- HALTED: outputs as DRAIN plus halted_o=1. Terminal until reset.
- Counters saturate at all-ones and do not wrap.
- Reset mid-operation (any state) returns to INIT immediately and clears counters.

Test Plan:
- Reset release: rst_i low 3 cycles then high -> one INIT cycle (pc_we=0, flushes=1, state_o=0), then state_o=1, pc_we=1, counters 0.
- Load-use stall: id src1 int=3 used, ex_wr_int=1 dest=3 for 1 cycle, then mem dest=3 for 1 cycle -> 2 cycles pc_we=0, idex_flush=1; stall_cnt=2; 3rd cycle pc_we=1.
- Cross-file no-hazard: id vec src=3 used, ex int dest=3 writing -> no stall, stall_cnt unchanged.
- Jump beats hazard: jump_taken_i=1 with active hazard -> pc_sel_jump=1, pc_we=1, all flushes=1, jump_cnt=1, stall_cnt unchanged.
- End with DRAIN_CYCLES=2: end_i pulse in RUN -> state 2 for 2 cycles, then state 3, halted_o=1; later jump_taken_i has no effect; reset low returns state_o=0 asynchronously.
- Saturation with CNT_BITS=4: hold hazard 20 cycles -> stall_cnt_o=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW-hazard stall, jump flush, end drain/halt sequencer with saturating perf counters
module pipe_hazard_ctrl #(
    parameter int REGI_BITS    = 4,
    parameter int VECT_BITS    = 2,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 id_valid_i,
    input  logic [REGI_BITS-1:0] id_src1_int_i,
    input  logic [REGI_BITS-1:0] id_src2_int_i,
    input  logic                 id_use1_int_i,
    input  logic                 id_use2_int_i,
    input  logic [VECT_BITS-1:0] id_src1_vec_i,
    input  logic [VECT_BITS-1:0] id_src2_vec_i,
    input  logic                 id_use1_vec_i,
    input  logic                 id_use2_vec_i,
    input  logic                 ex_wr_int_i,
    input  logic [REGI_BITS-1:0] ex_dest_int_i,
    input  logic                 ex_wr_vec_i,
    input  logic [VECT_BITS-1:0] ex_dest_vec_i,
    input  logic                 mem_wr_int_i,
    input  logic [REGI_BITS-1:0] mem_dest_int_i,
    input  logic                 mem_wr_vec_i,
    input  logic [VECT_BITS-1:0] mem_dest_vec_i,
    input  logic                 jump_taken_i,
    input  logic                 end_i,
    output logic                 pc_we_o,
    output logic                 ifid_we_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 exmem_flush_o,
    output logic                 pc_sel_jump_o,
    output logic                 halted_o,
    output logic [1:0]           state_o,
    output logic [CNT_BITS-1:0]  stall_cnt_o,
    output logic [CNT_BITS-1:0]  jump_cnt_o
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_DRAIN, S_HALTED} state_t;
    state_t              state_q, state_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic [CNT_BITS-1:0] stall_q, stall_d, jump_q, jump_d;
    logic                haz_int, haz_vec, hazard;
    assign haz_int = (id_use1_int_i && ((ex_wr_int_i && id_src1_int_i == ex_dest_int_i) ||
                                        (mem_wr_int_i && id_src1_int_i == mem_dest_int_i))) ||
                     (id_use2_int_i && ((ex_wr_int_i && id_src2_int_i == ex_dest_int_i) ||
                                        (mem_wr_int_i && id_src2_int_i == mem_dest_int_i)));
    assign haz_vec = (id_use1_vec_i && ((ex_wr_vec_i && id_src1_vec_i == ex_dest_vec_i) ||
                                        (mem_wr_vec_i && id_src1_vec_i == mem_dest_vec_i))) ||
                     (id_use2_vec_i && ((ex_wr_vec_i && id_src2_vec_i == ex_dest_vec_i) ||
                                        (mem_wr_vec_i && id_src2_vec_i == mem_dest_vec_i)));
    assign hazard  = id_valid_i && (haz_int || haz_vec);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_INIT;
            drain_q <= DW'(DRAIN_CYCLES);
            stall_q <= '0;
            jump_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            jump_q  <= jump_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        drain_d       = DW'(DRAIN_CYCLES);
        stall_d       = stall_q;
        jump_d        = jump_q;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
        pc_sel_jump_o = 1'b0;
        halted_o      = 1'b0;
        case (state_q)
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (end_i) begin
                    state_d = S_DRAIN;
                end else if (jump_taken_i) begin
                    pc_we_o       = 1'b1;
                    ifid_we_o     = 1'b1;
                    pc_sel_jump_o = 1'b1;
                    jump_d        = (&jump_q) ? jump_q : jump_q + CNT_BITS'(1);
                end else if (hazard) begin
                    ifid_flush_o  = 1'b0;
                    exmem_flush_o = 1'b0;
                    stall_d       = (&stall_q) ? stall_q : stall_q + CNT_BITS'(1);
                end else begin
                    pc_we_o       = 1'b1;
                    ifid_we_o     = 1'b1;
                    ifid_flush_o  = 1'b0;
                    idex_flush_o  = 1'b0;
                    exmem_flush_o = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q - DW'(1);
                state_d = (drain_q <= DW'(1)) ? S_HALTED : S_DRAIN;
            end
            S_HALTED: halted_o = 1'b1;
        endcase
    end
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;
    assign jump_cnt_o  = jump_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of reset, stalls, jump priority, saturation and drain/halt
module tb_pipe_hazard_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       id_valid_i;
    logic [3:0] id_src1_int_i, id_src2_int_i, ex_dest_int_i, mem_dest_int_i;
    logic       id_use1_int_i, id_use2_int_i, id_use1_vec_i, id_use2_vec_i;
    logic [1:0] id_src1_vec_i, id_src2_vec_i, ex_dest_vec_i, mem_dest_vec_i;
    logic       ex_wr_int_i, ex_wr_vec_i, mem_wr_int_i, mem_wr_vec_i, jump_taken_i, end_i;
    logic       pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o, halted_o;
    logic [1:0] state_o;
    logic [3:0] stall_cnt_o, jump_cnt_o;
    int total = 0;
    int bad = 0;

    pipe_hazard_ctrl #(.REGI_BITS(4), .VECT_BITS(2), .DRAIN_CYCLES(2), .CNT_BITS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .id_src1_int_i(id_src1_int_i), .id_src2_int_i(id_src2_int_i),
        .id_use1_int_i(id_use1_int_i), .id_use2_int_i(id_use2_int_i),
        .id_src1_vec_i(id_src1_vec_i), .id_src2_vec_i(id_src2_vec_i),
        .id_use1_vec_i(id_use1_vec_i), .id_use2_vec_i(id_use2_vec_i),
        .ex_wr_int_i(ex_wr_int_i), .ex_dest_int_i(ex_dest_int_i),
        .ex_wr_vec_i(ex_wr_vec_i), .ex_dest_vec_i(ex_dest_vec_i),
        .mem_wr_int_i(mem_wr_int_i), .mem_dest_int_i(mem_dest_int_i),
        .mem_wr_vec_i(mem_wr_vec_i), .mem_dest_vec_i(mem_dest_vec_i),
        .jump_taken_i(jump_taken_i), .end_i(end_i),
        .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
        .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
        .pc_sel_jump_o(pc_sel_jump_o), .halted_o(halted_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .jump_cnt_o(jump_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        id_valid_i = 0; id_src1_int_i = 0; id_src2_int_i = 0; id_use1_int_i = 0; id_use2_int_i = 0;
        id_src1_vec_i = 0; id_src2_vec_i = 0; id_use1_vec_i = 0; id_use2_vec_i = 0;
        ex_wr_int_i = 0; ex_dest_int_i = 0; ex_wr_vec_i = 0; ex_dest_vec_i = 0;
        mem_wr_int_i = 0; mem_dest_int_i = 0; mem_wr_vec_i = 0; mem_dest_vec_i = 0;
        jump_taken_i = 0; end_i = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 0;
        repeat (3) tick();
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if ({pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o, halted_o} !== 7'b0011100) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0011100", {pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o, halted_o}); end
        total++; if ({stall_cnt_o, jump_cnt_o} !== 8'h00) begin bad++; $display("FAIL reset_counters got=%h exp=00", {stall_cnt_o, jump_cnt_o}); end
        @(negedge clk_i);
        rst_i = 1;
        #1;
        total++; if (state_o !== 2'd0 || pc_we_o !== 1'b0) begin bad++; $display("FAIL init_cycle state=%0d pc_we=%b exp state=0 pc_we=0", state_o, pc_we_o); end
        tick();
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL run_state got=%0d exp=1", state_o); end
        total++; if (pc_we_o !== 1'b1 || ifid_we_o !== 1'b1 || idex_flush_o !== 1'b0) begin
            bad++; $display("FAIL run_normal pc_we=%b ifid_we=%b idex_flush=%b exp 1 1 0", pc_we_o, ifid_we_o, idex_flush_o); end
        total++; if ({stall_cnt_o, jump_cnt_o} !== 8'h00) begin bad++; $display("FAIL run_counters got=%h exp=00", {stall_cnt_o, jump_cnt_o}); end
    endtask

    task automatic test_load_use();
        id_valid_i = 1; id_src1_int_i = 3; id_use1_int_i = 1; ex_wr_int_i = 1; ex_dest_int_i = 3;
        #1;
        total++; if ({pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o} !== 5'b00010) begin
            bad++; $display("FAIL stall_ex_outputs got=%b exp=00010", {pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o}); end
        tick();
        total++; if (stall_cnt_o !== 4'd1) begin bad++; $display("FAIL stall_cnt_1 got=%0d exp=1", stall_cnt_o); end
        ex_wr_int_i = 0; mem_wr_int_i = 1; mem_dest_int_i = 3;
        #1;
        total++; if (pc_we_o !== 1'b0 || idex_flush_o !== 1'b1) begin bad++; $display("FAIL stall_mem pc_we=%b idex_flush=%b exp 0 1", pc_we_o, idex_flush_o); end
        tick();
        total++; if (stall_cnt_o !== 4'd2) begin bad++; $display("FAIL stall_cnt_2 got=%0d exp=2", stall_cnt_o); end
        mem_wr_int_i = 0;
        #1;
        total++; if (pc_we_o !== 1'b1 || idex_flush_o !== 1'b0) begin bad++; $display("FAIL stall_release pc_we=%b idex_flush=%b exp 1 0", pc_we_o, idex_flush_o); end
        id_use1_int_i = 0; mem_wr_int_i = 1;
        #1;
        total++; if (pc_we_o !== 1'b1) begin bad++; $display("FAIL unused_src pc_we=%b exp=1", pc_we_o); end
        id_src2_int_i = 0; id_use2_int_i = 1; mem_dest_int_i = 0;
        #1;
        total++; if (pc_we_o !== 1'b0) begin bad++; $display("FAIL reg0_hazard pc_we=%b exp=0", pc_we_o); end
        tick();
        total++; if (stall_cnt_o !== 4'd3) begin bad++; $display("FAIL stall_cnt_3 got=%0d exp=3", stall_cnt_o); end
        idle();
    endtask

    task automatic test_cross_file();
        id_valid_i = 1; id_src1_vec_i = 3; id_use1_vec_i = 1; ex_wr_int_i = 1; ex_dest_int_i = 3;
        #1;
        total++; if (pc_we_o !== 1'b1) begin bad++; $display("FAIL cross_file pc_we=%b exp=1", pc_we_o); end
        tick();
        total++; if (stall_cnt_o !== 4'd3) begin bad++; $display("FAIL cross_file_cnt got=%0d exp=3", stall_cnt_o); end
        ex_wr_vec_i = 1; ex_dest_vec_i = 3;
        #1;
        total++; if (pc_we_o !== 1'b0) begin bad++; $display("FAIL vec_hazard pc_we=%b exp=0", pc_we_o); end
        id_valid_i = 0;
        #1;
        total++; if (pc_we_o !== 1'b1) begin bad++; $display("FAIL invalid_id pc_we=%b exp=1", pc_we_o); end
        tick();
        total++; if (stall_cnt_o !== 4'd3) begin bad++; $display("FAIL invalid_id_cnt got=%0d exp=3", stall_cnt_o); end
        idle();
    endtask

    task automatic test_jump();
        id_valid_i = 1; id_src1_int_i = 5; id_use1_int_i = 1; ex_wr_int_i = 1; ex_dest_int_i = 5; jump_taken_i = 1;
        #1;
        total++; if ({pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o} !== 6'b111111) begin
            bad++; $display("FAIL jump_outputs got=%b exp=111111", {pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o}); end
        tick();
        total++; if (jump_cnt_o !== 4'd1 || stall_cnt_o !== 4'd3) begin
            bad++; $display("FAIL jump_counts jump=%0d stall=%0d exp 1 3", jump_cnt_o, stall_cnt_o); end
        jump_taken_i = 0;
    endtask

    task automatic test_saturation();
        repeat (20) tick();
        total++; if (stall_cnt_o !== 4'd15) begin bad++; $display("FAIL stall_saturate got=%0d exp=15", stall_cnt_o); end
        total++; if (pc_we_o !== 1'b0) begin bad++; $display("FAIL sat_still_stall pc_we=%b exp=0", pc_we_o); end
        idle();
    endtask

    task automatic test_end();
        end_i = 1; jump_taken_i = 1;
        #1;
        total++; if ({pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o} !== 6'b001110) begin
            bad++; $display("FAIL end_outputs got=%b exp=001110", {pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o, exmem_flush_o, pc_sel_jump_o}); end
        tick();
        total++; if (state_o !== 2'd2 || jump_cnt_o !== 4'd1) begin bad++; $display("FAIL drain_enter state=%0d jump=%0d exp 2 1", state_o, jump_cnt_o); end
        end_i = 0;
        #1;
        total++; if (pc_sel_jump_o !== 1'b0 || pc_we_o !== 1'b0) begin bad++; $display("FAIL drain_ignore_jump sel=%b pc_we=%b exp 0 0", pc_sel_jump_o, pc_we_o); end
        tick();
        total++; if (state_o !== 2'd2 || halted_o !== 1'b0) begin bad++; $display("FAIL drain_second state=%0d halted=%b exp 2 0", state_o, halted_o); end
        tick();
        total++; if (state_o !== 2'd3 || halted_o !== 1'b1) begin bad++; $display("FAIL halted state=%0d halted=%b exp 3 1", state_o, halted_o); end
        repeat (2) tick();
        total++; if (state_o !== 2'd3 || pc_we_o !== 1'b0 || pc_sel_jump_o !== 1'b0 || jump_cnt_o !== 4'd1) begin
            bad++; $display("FAIL halted_sticky state=%0d pc_we=%b sel=%b jump=%0d exp 3 0 0 1", state_o, pc_we_o, pc_sel_jump_o, jump_cnt_o); end
        jump_taken_i = 0;
        #2;
        rst_i = 0;
        #1;
        total++; if (state_o !== 2'd0 || halted_o !== 1'b0 || {stall_cnt_o, jump_cnt_o} !== 8'h00) begin
            bad++; $display("FAIL async_reset state=%0d halted=%b cnt=%h exp 0 0 00", state_o, halted_o, {stall_cnt_o, jump_cnt_o}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        rst_i = 1;
        tick();
        total++; if (state_o !== 2'd1 || pc_we_o !== 1'b1) begin bad++; $display("FAIL rerun state=%0d pc_we=%b exp 1 1", state_o, pc_we_o); end
        jump_taken_i = 1;
        tick();
        tick();
        total++; if (jump_cnt_o !== 4'd2) begin bad++; $display("FAIL b2b_jumps got=%0d exp=2", jump_cnt_o); end
        jump_taken_i = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_cross_file();
        test_jump();
        test_saturation();
        test_end();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
